// File: rtl/pad_trig_pkg.sv
// Shared types and constants for the pad hit framing path.
package pad_trig_pkg;

    localparam int N_PADS     = 104;
    localparam int CHAN_W     = 7;
    localparam int FRAME_ID_W = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        CLEAR = 2'd3
    } state_e;

    typedef logic [N_PADS-1:0] pad_map_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/pad_hit_frame_builder_chan_decoder.sv
// Channel index to one-hot pad mask; mask and in-range flag are zero unless strobed.
module pad_chan_decoder
    import pad_trig_pkg::*;
(
    input  logic              strobe_i,
    input  logic [CHAN_W-1:0] chan_i,
    output pad_map_t          mask_o,
    output logic              in_range_o
);

    always_comb begin
        mask_o = '0;
        for (int i = 0; i < N_PADS; i++) begin
            mask_o[i] = strobe_i && (chan_i == CHAN_W'(i));
        end
    end

    assign in_range_o = strobe_i && (chan_i < CHAN_W'(N_PADS));

endmodule

// File: rtl/pad_hit_frame_builder.sv
// Collects pad hit events into one bitmap per frame and emits it as a single-cycle pulse.
// Optional PAD_HIT_COUNT_EN adds hit_count_o (in-range hits in the emitted frame).
//
// state | meaning
// IDLE  | framing stopped, hits refused, cycle counter held at 0
// RUN   | accepting hits, frames emitted at every boundary
// DRAIN | enable dropped: finish current frame, emit it, then IDLE
// CLEAR | one-cycle downstream clear; frame state wiped
module pad_hit_frame_builder
    import pad_trig_pkg::*;
#(
    parameter int FRAME_CYCLES = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  enable_i,
    input  logic                  clear_req_i,
    input  logic                  hit_valid_i,
    input  logic [CHAN_W-1:0]     hit_chan_i,
    output logic                  hit_ready_o,
    output logic [N_PADS-1:0]     pad_data_o,
    output logic                  pad_data_valid_o,
    output logic                  pad_hit_clear_o,
    output logic [FRAME_ID_W-1:0] frame_id_o,
    output logic [15:0]           drop_cnt_o
`ifdef PAD_HIT_COUNT_EN
    ,
    output logic [7:0]            hit_count_o
`endif
);

    localparam logic [7:0] FRAME_LAST = 8'(FRAME_CYCLES - 1);

    state_e                state_q, state_d;
    logic [7:0]            cyc_q, cyc_d;
    pad_map_t              acc_q, acc_d;
    pad_map_t              pad_data_q, pad_data_d;
    logic                  valid_q, valid_d;
    logic [FRAME_ID_W-1:0] fid_q, fid_d;
    logic [15:0]           drop_q, drop_d;

    logic                  active;
    logic                  accept;
    logic                  frame_end;
    logic                  wipe;
    logic                  in_range;
    pad_map_t              hit_mask;

    assign active    = (state_q == RUN) || (state_q == DRAIN);
    assign accept    = hit_valid_i && active;
    assign frame_end = active && (cyc_q == FRAME_LAST);
    // A clear request wins over everything, including a coincident boundary.
    assign wipe      = clear_req_i || (state_q == CLEAR);

    pad_chan_decoder u_dec (
        .strobe_i   (accept),
        .chan_i     (hit_chan_i),
        .mask_o     (hit_mask),
        .in_range_o (in_range)
    );

    always_comb begin
        state_d = state_q;
        if (clear_req_i) begin
            state_d = CLEAR;
        end else begin
            case (state_q)
                IDLE:    if (enable_i) state_d = RUN;
                RUN:     if (!enable_i) state_d = frame_end ? IDLE : DRAIN;
                DRAIN: begin
                    if (enable_i)       state_d = RUN;
                    else if (frame_end) state_d = IDLE;
                end
                CLEAR:   state_d = enable_i ? RUN : IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        acc_d      = acc_q;
        cyc_d      = cyc_q;
        pad_data_d = pad_data_q;
        valid_d    = 1'b0;
        fid_d      = fid_q;
        drop_d     = drop_q;
        if (wipe) begin
            acc_d  = '0;
            cyc_d  = '0;
            fid_d  = '0;
            drop_d = '0;
        end else if (active) begin
            if (accept && !in_range) begin
                drop_d = sat_inc16(drop_q);
            end
            // The hit accepted in the last cycle still belongs to the closing frame.
            if (frame_end) begin
                pad_data_d = acc_q | hit_mask;
                valid_d    = 1'b1;
                acc_d      = '0;
                cyc_d      = '0;
                fid_d      = fid_q + FRAME_ID_W'(1);
            end else begin
                acc_d = acc_q | hit_mask;
                cyc_d = cyc_q + 8'd1;
            end
        end else begin
            cyc_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cyc_q      <= '0;
            acc_q      <= '0;
            pad_data_q <= '0;
            valid_q    <= 1'b0;
            fid_q      <= '0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            acc_q      <= acc_d;
            pad_data_q <= pad_data_d;
            valid_q    <= valid_d;
            fid_q      <= fid_d;
            drop_q     <= drop_d;
        end
    end

`ifdef PAD_HIT_COUNT_EN
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] hcnt_q, hcnt_d;
    logic [7:0] cnt_inc;

    always_comb begin
        cnt_inc = in_range ? sat_inc8(cnt_q) : cnt_q;
        cnt_d   = cnt_q;
        hcnt_d  = hcnt_q;
        if (wipe) begin
            cnt_d  = '0;
            hcnt_d = '0;
        end else if (frame_end) begin
            hcnt_d = cnt_inc;
            cnt_d  = '0;
        end else if (active) begin
            cnt_d = cnt_inc;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            hcnt_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            hcnt_q <= hcnt_d;
        end
    end

    assign hit_count_o = hcnt_q;
`endif

    assign hit_ready_o      = active;
    assign pad_data_o       = pad_data_q;
    assign pad_data_valid_o = valid_q;
    assign pad_hit_clear_o  = (state_q == CLEAR);
    assign frame_id_o       = fid_q;
    assign drop_cnt_o       = drop_q;

endmodule
